// File: rtl/core_pkg.sv
`default_nettype none
//============================================================================
// Module      : core_pkg
// Description : Shared types and default constants for the core pipeline
//               control logic.
// Revision    : 1.0 - initial release
//============================================================================
package core_pkg;

    localparam int NUM_STAGES_DEFAULT      = 5;
    localparam int REDIRECT_CYCLES_DEFAULT = 2;
    localparam int STAGE_IDX_W_DEFAULT     = $clog2(NUM_STAGES_DEFAULT);

    // Stage index sized for the default pipeline depth
    typedef logic [STAGE_IDX_W_DEFAULT-1:0] stage_idx_t;

    // Pipeline control sequencing states
    typedef enum logic [1:0] {
        CTRL_IDLE     = 2'd0,
        CTRL_DRAIN    = 2'd1,
        CTRL_REDIRECT = 2'd2
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/core_redirect_counter.sv
`default_nettype none
//============================================================================
// Module      : core_redirect_counter
// Description : Loadable saturating down-counter. 'active' is high while the
//               count is non-zero. A load overrides any count in progress.
// Revision    : 1.0 - initial release
//============================================================================
module core_redirect_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             active
);

    logic [WIDTH-1:0] r_count;

    // Reload on request, otherwise count down and stick at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign active = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/core_pipeline_control.sv
`default_nettype none
//============================================================================
// Module      : core_pipeline_control
// Description : Per-stage valid tracking and advance/flush generation for an
//               in-order pipeline, with branch redirects and precise traps.
//               Stage 0 is the youngest (fed by fetch), NUM_STAGES-1 oldest.
// Revision    : 1.0 - initial release
//============================================================================
module core_pipeline_control
    import core_pkg::*;
#(
    parameter int NUM_STAGES      = NUM_STAGES_DEFAULT,
    parameter int REDIRECT_CYCLES = REDIRECT_CYCLES_DEFAULT,
    parameter int STAGE_IDX_W     = $clog2(NUM_STAGES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_valid,
    input  logic [NUM_STAGES-1:0]  stage_busy,
    input  logic                   branch_en,
    input  logic [STAGE_IDX_W-1:0] branch_stage_idx,
    input  logic                   trap_req,
    input  logic [STAGE_IDX_W-1:0] trap_stage_idx,
    output logic [NUM_STAGES-1:0]  stage_valid,
    output logic [NUM_STAGES-1:0]  stage_advance,
    output logic [NUM_STAGES-1:0]  stage_flush,
    output logic                   invalidate_fetch,
    output logic                   trap_redirect,
    output logic                   pipeline_empty
);

    // A single-cycle window still needs a one-bit counter port
    localparam int               CNT_W        = (REDIRECT_CYCLES > 1) ? $clog2(REDIRECT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_RELOAD = CNT_W'(REDIRECT_CYCLES - 1);

    ctrl_state_e            r_state;
    logic [STAGE_IDX_W-1:0] r_trap_idx;
    logic [NUM_STAGES-1:0]  r_valid;

    logic                   w_branch_ok;
    logic                   w_trap_ok;
    logic                   w_branch_acc;
    logic                   w_trap_acc;
    logic                   w_older_valid;
    logic                   w_cnt_load;
    logic                   w_cnt_active;
    logic                   w_inval;
    logic [NUM_STAGES-1:0]  w_hold;
    logic [NUM_STAGES-1:0]  w_flush;
    logic [NUM_STAGES-1:0]  w_valid_nxt;

    // Decide which redirect request (if any) is taken this cycle
    always_comb begin
        w_branch_ok  = branch_en && (int'(branch_stage_idx) < NUM_STAGES);
        w_trap_ok    = trap_req  && (int'(trap_stage_idx)   < NUM_STAGES);
        w_branch_acc = 1'b0;
        w_trap_acc   = 1'b0;
        case (r_state)
            CTRL_IDLE: begin
                // An older branch squashes the trapping instruction itself
                w_trap_acc   = w_trap_ok && !(w_branch_ok && (branch_stage_idx > trap_stage_idx));
                w_branch_acc = w_branch_ok && !w_trap_acc;
            end
            CTRL_DRAIN: begin
                // Only a branch older than the trap can cancel it
                w_branch_acc = w_branch_ok && (branch_stage_idx > r_trap_idx);
            end
            default: ;
        endcase
    end

    // Flush mask: stages younger than a branch, up to and including a trap
    always_comb begin
        w_flush       = '0;
        w_older_valid = 1'b0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            w_flush[j] = (w_branch_acc && (j <  int'(branch_stage_idx))) ||
                         (w_trap_acc   && (j <= int'(trap_stage_idx)))   ||
                         ((r_state == CTRL_DRAIN) && (j <= int'(r_trap_idx)));
            if (j > int'(r_trap_idx)) begin
                w_older_valid = w_older_valid | r_valid[j];
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
            logic w_hold_s;
            logic w_load;

            // Stage i holds when a contiguous run of valid stages from i reaches a busy stage
            always_comb begin : p_hold
                logic w_run;
                w_run    = 1'b1;
                w_hold_s = 1'b0;
                for (int k = i; k < NUM_STAGES; k++) begin
                    w_run    = w_run & r_valid[k];
                    w_hold_s = w_hold_s | (w_run & stage_busy[k]);
                end
            end

            assign w_hold[i] = w_hold_s;

            if (i == 0) begin : g_head
                assign w_load = fetch_valid & ~w_inval;
            end else begin : g_body
                assign w_load = r_valid[i-1] & ~w_hold[i-1] & ~w_flush[i-1];
            end

            // Flush beats hold, hold beats load
            assign w_valid_nxt[i] = w_flush[i] ? 1'b0 : (w_hold[i] ? r_valid[i] : w_load);
        end
    endgenerate

    // Per-stage valid register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    // Trap sequencing: drain older stages, then issue the trap redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CTRL_IDLE;
            r_trap_idx <= '0;
        end else begin
            case (r_state)
                CTRL_IDLE: begin
                    if (w_trap_acc) begin
                        r_state    <= CTRL_DRAIN;
                        r_trap_idx <= trap_stage_idx;
                    end
                end
                CTRL_DRAIN: begin
                    if (w_branch_acc) begin
                        r_state <= CTRL_IDLE;
                    end else if (!w_older_valid) begin
                        r_state <= CTRL_REDIRECT;
                    end
                end
                CTRL_REDIRECT: begin
                    r_state <= CTRL_IDLE;
                end
                default: begin
                    r_state <= CTRL_IDLE;
                end
            endcase
        end
    end

    // Both branch redirects and the trap redirect open a fresh invalidate window
    assign w_cnt_load = w_branch_acc | (r_state == CTRL_REDIRECT);

    core_redirect_counter #(
        .WIDTH    (CNT_W)
    ) u_redirect_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (C_CNT_RELOAD),
        .active   (w_cnt_active)
    );

    assign w_inval = w_branch_acc | w_trap_acc | (r_state != CTRL_IDLE) | w_cnt_active;

    assign stage_valid      = r_valid;
    assign stage_advance    = rst ? '0 : ~w_hold;
    assign stage_flush      = rst ? '0 : w_flush;
    assign invalidate_fetch = w_inval & ~rst;
    assign trap_redirect    = (r_state == CTRL_REDIRECT) & ~rst;
    assign pipeline_empty   = ~|r_valid;

    // Flag out-of-range stage indices; such requests are otherwise ignored
    always_ff @(posedge clk) begin
        if (!rst && branch_en) begin
            assert (int'(branch_stage_idx) < NUM_STAGES);
        end
        if (!rst && trap_req) begin
            assert (int'(trap_stage_idx) < NUM_STAGES);
        end
    end

endmodule
`default_nettype wire
